accumulator_unit: RTL and testbench

Sequential 32-bit accumulator/ALU stage between the input barrel shifter and the output parallel shifter in the DSP datapath. It consumes the sign-extended 32-bit barrel-shifter result as its operand and holds the accumulator. The accumulator drives the parallel shifter's 32-bit input. Supports load, add, subtract, logic, overflow-mode saturation, sticky status flags, and a multi-cycle NORM (normalize) operation, all behind a valid/ready handshake.

---
 rtl/accumulator_unit.sv | 147 ++++++++++++++
 tb/tb_accumulator_unit.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/accumulator_unit.sv
// Accumulator/ALU stage between the barrel shifter and the parallel shifter.
// Single-cycle load/arith/logic ops plus a multi-cycle normalize.
module accumulator_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CW    = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] operand,
  input  logic             ovm,
  output logic [WIDTH-1:0] acc,
  output logic             c,
  output logic             ov,
  output logic             z,
  output logic             n,
  output logic [CW-1:0]    norm_count,
  output logic             done
);

  localparam logic [2:0] OP_NOP   = 3'b000;
  localparam logic [2:0] OP_LAC   = 3'b001;
  localparam logic [2:0] OP_ADD   = 3'b010;
  localparam logic [2:0] OP_SUB   = 3'b011;
  localparam logic [2:0] OP_AND   = 3'b100;
  localparam logic [2:0] OP_OR    = 3'b101;
  localparam logic [2:0] OP_NORM  = 3'b110;
  localparam logic [2:0] OP_CLROV = 3'b111;

  localparam logic [WIDTH-1:0] MAX_POS    = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MAX_NEG    = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CW-1:0]    NORM_LIMIT = CW'(WIDTH-1);

  typedef enum logic {IDLE, NORM} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_d;
  logic             c_d, ov_d, z_d, n_d, done_d, upd_zn;
  logic [CW-1:0]    cnt_d;
  logic [WIDTH:0]   sum, diff;
  logic             add_ovf, sub_ovf, norm_term;
  logic [WIDTH-1:0] sat_val;

  // Next-state and datapath
  always_comb begin
    state_d = state_q;
    acc_d   = acc;
    c_d     = c;
    ov_d    = ov;
    z_d     = z;
    n_d     = n;
    cnt_d   = norm_count;
    done_d  = 1'b0;
    upd_zn  = 1'b0;

    sum     = {1'b0, acc} + {1'b0, operand};
    diff    = {1'b0, acc} - {1'b0, operand};
    add_ovf = (acc[WIDTH-1] == operand[WIDTH-1]) && (sum[WIDTH-1] != acc[WIDTH-1]);
    sub_ovf = (acc[WIDTH-1] != operand[WIDTH-1]) && (diff[WIDTH-1] != acc[WIDTH-1]);
    // Overflow direction always follows the sign of the accumulator
    sat_val = acc[WIDTH-1] ? MAX_NEG : MAX_POS;
    norm_term = (acc == '0) || (acc[WIDTH-1] != acc[WIDTH-2]) || (norm_count == NORM_LIMIT);

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          done_d = (op != OP_NORM);
          case (op)
            OP_NOP: ;
            OP_LAC: begin
              acc_d  = operand;
              upd_zn = 1'b1;
            end
            OP_ADD: begin
              c_d    = sum[WIDTH];
              acc_d  = (add_ovf && ovm) ? sat_val : sum[WIDTH-1:0];
              ov_d   = ov | add_ovf;
              upd_zn = 1'b1;
            end
            OP_SUB: begin
              c_d    = ~diff[WIDTH];
              acc_d  = (sub_ovf && ovm) ? sat_val : diff[WIDTH-1:0];
              ov_d   = ov | sub_ovf;
              upd_zn = 1'b1;
            end
            OP_AND: begin
              acc_d  = acc & operand;
              upd_zn = 1'b1;
            end
            OP_OR: begin
              acc_d  = acc | operand;
              upd_zn = 1'b1;
            end
            OP_NORM: begin
              cnt_d   = '0;
              state_d = NORM;
            end
            OP_CLROV: ov_d = 1'b0;
          endcase
        end
      end
      NORM: begin
        if (norm_term) begin
          state_d = IDLE;
          done_d  = 1'b1;
          upd_zn  = 1'b1;
        end else begin
          acc_d = {acc[WIDTH-2:0], 1'b0};
          cnt_d = norm_count + CW'(1);
        end
      end
    endcase

    if (upd_zn) begin
      z_d = (acc_d == '0);
      n_d = acc_d[WIDTH-1];
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      in_ready   <= 1'b1;
      acc        <= '0;
      c          <= 1'b0;
      ov         <= 1'b0;
      z          <= 1'b1;
      n          <= 1'b0;
      norm_count <= '0;
      done       <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_ready   <= (state_d == IDLE);
      acc        <= acc_d;
      c          <= c_d;
      ov         <= ov_d;
      z          <= z_d;
      n          <= n_d;
      norm_count <= cnt_d;
      done       <= done_d;
    end
  end

endmodule

// File: tb/tb_accumulator_unit.sv
// Bench for accumulator_unit: transaction-level reference model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_accumulator_unit;

  logic        clk, reset, in_valid, in_ready, ovm;
  logic [2:0]  op;
  logic [31:0] operand, acc;
  logic        c, ov, z, n, done;
  logic [4:0]  norm_count;

  int errors = 0;
  int checks = 0;

  accumulator_unit #(.WIDTH(32), .CW(5)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .operand(operand), .ovm(ovm), .acc(acc), .c(c), .ov(ov),
    .z(z), .n(n), .norm_count(norm_count), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] e_acc, pend_acc;
  logic        e_c, e_ov, e_z, e_n, e_done, e_ready;
  logic [4:0]  e_cnt, pend_cnt;
  int          busy = 0;
  bit          started = 0;

  // Shifts a normalize performs: redundant leading sign bits, capped at 31
  function automatic int norm_shifts(input logic [31:0] x);
    int  lead = 0;
    bit  run  = 1;
    if (x == 32'h0) return 0;
    for (int i = 31; i >= 0; i--) begin
      if (run && x[i] == x[31]) lead++;
      else run = 0;
    end
    return lead - 1;
  endfunction

  always @(posedge clk) begin
    longint sa, sb, r;
    int     k;
    if (reset) begin
      started = 1;
      e_acc = 0; e_c = 0; e_ov = 0; e_z = 1; e_n = 0; e_cnt = 0;
      e_done = 0; e_ready = 1; busy = 0;
    end else if (started) begin
      e_done = 0;
      if (busy > 0) begin
        busy--;
        if (busy == 0) begin
          e_acc = pend_acc; e_cnt = pend_cnt;
          e_z = (e_acc == 0); e_n = e_acc[31];
          e_done = 1; e_ready = 1;
        end
      end else if (in_valid) begin
        sa = $signed(e_acc);
        sb = $signed(operand);
        case (op)
          3'd0: e_done = 1;
          3'd1: begin e_acc = operand; e_done = 1; end
          3'd2, 3'd3: begin
            if (op == 3'd2) begin
              r   = sa + sb;
              e_c = ((longint'(e_acc) + longint'(operand)) > 64'sd4294967295);
            end else begin
              r   = sa - sb;
              e_c = (e_acc >= operand);
            end
            if (r > 64'sd2147483647) begin
              e_ov = 1; e_acc = ovm ? 32'h7FFFFFFF : 32'(r);
            end else if (r < -64'sd2147483648) begin
              e_ov = 1; e_acc = ovm ? 32'h80000000 : 32'(r);
            end else e_acc = 32'(r);
            e_done = 1;
          end
          3'd4: begin e_acc = e_acc & operand; e_done = 1; end
          3'd5: begin e_acc = e_acc | operand; e_done = 1; end
          3'd6: begin
            k        = norm_shifts(e_acc);
            pend_acc = e_acc << k;
            pend_cnt = 5'(k);
            busy     = k + 1;
            e_ready  = 0;
          end
          default: begin e_ov = 0; e_done = 1; end
        endcase
        if (op inside {3'd1, 3'd2, 3'd3, 3'd4, 3'd5}) begin
          e_z = (e_acc == 0); e_n = e_acc[31];
        end
      end
    end
  end

  // Every-cycle comparison; acc/norm_count are intermediate while normalizing
  always @(negedge clk) begin
    if (started) begin
      chk("in_ready", 32'(in_ready), 32'(e_ready));
      chk("done", 32'(done), 32'(e_done));
      chk("c", 32'(c), 32'(e_c));
      chk("ov", 32'(ov), 32'(e_ov));
      chk("z", 32'(z), 32'(e_z));
      chk("n", 32'(n), 32'(e_n));
      if (e_ready) begin
        chk("acc", acc, e_acc);
        chk("norm_count", 32'(norm_count), 32'(e_cnt));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_ready();
    int t = 0;
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) chk("ready_timeout", 32'(in_ready), 32'd1);
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] d, input logic m);
    wait_ready();
    in_valid = 1; op = o; operand = d; ovm = m;
    @(negedge clk);
    in_valid = 0;
  endtask

  // Counts busy cycles after a NORM accept, optionally poking ignored requests
  task automatic count_busy(input bit poke, output int cyc);
    cyc = 0;
    if (poke) begin in_valid = 1; op = 3'd1; operand = 32'hDEADBEEF; end
    while (!in_ready && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    in_valid = 0;
  endtask

  initial begin
    int cyc;
    reset = 1; in_valid = 0; op = 0; operand = 0; ovm = 0;
    repeat (2) @(negedge clk);
    chk("rst_acc", acc, 32'h0);
    chk("rst_z", 32'(z), 32'd1);
    chk("rst_ready", 32'(in_ready), 32'd1);
    reset = 0;
    @(negedge clk);

    // 1: load negative value
    issue(3'd1, 32'hFFFABCD0, 0);
    chk("t1_acc", acc, 32'hFFFABCD0);
    chk("t1_n", 32'(n), 32'd1);
    chk("t1_z", 32'(z), 32'd0);
    chk("t1_c", 32'(c), 32'd0);
    chk("t1_done", 32'(done), 32'd1);
    @(negedge clk);
    chk("t1_done_low", 32'(done), 32'd0);

    // 2: overflow wrap, saturate, clear
    issue(3'd1, 32'h1, 0);
    issue(3'd2, 32'h7FFFFFFF, 0);
    chk("t2_wrap_acc", acc, 32'h80000000);
    chk("t2_wrap_ov", 32'(ov), 32'd1);
    chk("t2_wrap_n", 32'(n), 32'd1);
    issue(3'd1, 32'h1, 0);
    issue(3'd2, 32'h7FFFFFFF, 1);
    chk("t2_sat_acc", acc, 32'h7FFFFFFF);
    chk("t2_sat_ov", 32'(ov), 32'd1);
    issue(3'd7, 32'h0, 0);
    chk("t2_clrov", 32'(ov), 32'd0);

    // 3: subtract borrow / no borrow
    issue(3'd1, 32'h0, 0);
    issue(3'd3, 32'h1, 0);
    chk("t3_acc", acc, 32'hFFFFFFFF);
    chk("t3_c", 32'(c), 32'd0);
    chk("t3_ov", 32'(ov), 32'd0);
    issue(3'd3, 32'hFFFFFFFF, 0);
    chk("t3b_acc", acc, 32'h0);
    chk("t3b_z", 32'(z), 32'd1);
    chk("t3b_c", 32'(c), 32'd1);

    // 4: normalize with an ignored request during busy
    issue(3'd1, 32'h00012340, 0);
    issue(3'd6, 32'h0, 0);
    count_busy(1, cyc);
    chk("t4_busy", 32'(cyc), 32'd15);
    chk("t4_acc", acc, 32'h48D00000);
    chk("t4_cnt", 32'(norm_count), 32'd14);
    chk("t4_done", 32'(done), 32'd1);

    // 5: normalize edge cases
    issue(3'd1, 32'h0, 0);
    issue(3'd6, 32'h0, 0);
    count_busy(0, cyc);
    chk("t5_zero_busy", 32'(cyc), 32'd1);
    chk("t5_zero_cnt", 32'(norm_count), 32'd0);
    chk("t5_zero_z", 32'(z), 32'd1);
    issue(3'd1, 32'hFFFFFFFF, 0);
    issue(3'd6, 32'h0, 0);
    count_busy(0, cyc);
    chk("t5_ones_acc", acc, 32'h80000000);
    chk("t5_ones_cnt", 32'(norm_count), 32'd31);

    // 6: reset in the middle of a normalize
    issue(3'd1, 32'h1, 0);
    issue(3'd6, 32'h0, 0);
    repeat (4) @(negedge clk);
    reset = 1;
    @(negedge clk);
    reset = 0;
    chk("t6_acc", acc, 32'h0);
    chk("t6_cnt", 32'(norm_count), 32'd0);
    chk("t6_z", 32'(z), 32'd1);
    chk("t6_ready", 32'(in_ready), 32'd1);
    chk("t6_done", 32'(done), 32'd0);

    // Random traffic, model-checked every cycle
    repeat (3000) begin
      @(negedge clk);
      reset    = ($urandom_range(0, 399) == 0);
      in_valid = ($urandom_range(0, 3) != 0);
      op       = 3'($urandom_range(0, 7));
      ovm      = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 7))
        0: operand = 32'h0;
        1: operand = 32'h7FFFFFFF;
        2: operand = 32'h80000000;
        3: operand = 32'hFFFFFFFF;
        4: operand = 32'($urandom_range(0, 255));
        default: operand = $urandom;
      endcase
    end
    reset = 0; in_valid = 0;
    repeat (40) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
